boundary_down_streamer: RTL
===========================

BOUNDARY_DOWN_STREAMER -- requirements
Module: boundary_down_streamer

Interface
REQ-001 Parameter MAX_COUNT, default 10: bound on counted values; W = $clog2(MAX_COUNT) is the width of every value port.
REQ-002 Parameter WRAP, default 1: 1 = restart from max after min is accepted; 0 = one pass, then return to idle.
REQ-003 clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_in  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-005 start_in  input  1  request to latch bounds and begin a descending pass.
REQ-006 max_in  input  W  upper bound (first value emitted), sampled only on an accepted start.
REQ-007 min_in  input  W  lower bound (last value emitted), sampled only on an accepted start.
REQ-008 stop_in  input  1  request for graceful stop after the next accepted beat.
REQ-009 count_valid_out  output  1  count_out holds a valid value.
REQ-010 count_ready_in  input  1  consumer accepts; beat completes when valid and ready are both 1.
REQ-011 count_out  output  W  current value, counting max down to min inclusive.
REQ-012 last_out  output  1  high with valid when count_out == latched min.
REQ-013 busy_out  output  1  high in RUN state.
REQ-014 err_out  output  1  one-cycle pulse on a rejected start (min_in > max_in).

Function
REQ-015 Two states: IDLE and RUN; IDLE after reset.
REQ-016 IDLE: count_valid_out = 0, last_out = 0, busy_out = 0; count_out holds its last value.
REQ-017 IDLE, start_in = 1, min_in <= max_in: latch both bounds, count_out <= max_in, go to RUN; valid rises the cycle after start (1-cycle latency).
REQ-018 IDLE, start_in = 1, min_in > max_in: err_out = 1 for the next cycle only, stay IDLE, bounds unchanged.
REQ-019 RUN: count_valid_out = 1 continuously; count_out and last_out stay stable until a beat completes.
REQ-020 Beat with count_out != min: count_out <= count_out - 1 next cycle.
REQ-021 Beat with count_out == min, WRAP = 1, no stop pending: count_out <= latched max, stay RUN.
REQ-022 Beat with count_out == min, WRAP = 0: go to IDLE.
REQ-023 stop_in = 1 in RUN sets a sticky stop-pending flag; the next completed beat (including one in the same cycle as stop_in) sends the block to IDLE.
REQ-024 No beat in a cycle (valid with ready = 0): state and count_out unchanged; stop stays pending.
REQ-025 start_in is ignored in RUN; bounds can change only via an accepted start from IDLE.
REQ-026 min == max: single value emitted with last_out = 1 on every beat; WRAP = 1 repeats it.
REQ-027 Arithmetic is W-bit unsigned; decrement never goes below latched min, so no underflow wrap occurs; min = 0 is legal.
REQ-028 Start on the cycle the block enters IDLE is honoured on the following cycle only, not in the same cycle as the final beat.

Reset
REQ-029 rst_in = 0 immediately forces IDLE, count_out = 0, count_valid_out = 0, last_out = 0, busy_out = 0, err_out = 0, stop-pending cleared, latched bounds = 0.
REQ-030 Reset mid-pass aborts without a final beat; after release, no output until a new start.
REQ-031 The first accepted start is the first rising edge with rst_in = 1 and start_in = 1.

Verification
REQ-032 WRAP=0, start max=5 min=2, ready=1 -> count_out 5,4,3,2 on consecutive cycles, last_out only with 2, then IDLE with valid=0.
REQ-033 WRAP=1, max=3 min=1, ready=1 for 7 cycles -> 3,2,1,3,2,1,3; last_out with each 1.
REQ-034 Backpressure: max=4 min=0, ready toggling 1,0,0,1 -> value held stable while ready=0; sequence 4,3,3,3,2 across cycles.
REQ-035 Bad bounds: start max=2 min=6 -> err_out one cycle, valid stays 0; a following start max=6 min=2 succeeds.
REQ-036 Stop: WRAP=1, max=9 min=0, stop_in with ready=0 while count_out=7 -> 7 held, one beat accepted, then IDLE; no 6 emitted.
REQ-037 Async reset: assert rst_in=0 mid-cycle during RUN at count 5 -> outputs zero before next clock edge; start ignored in RUN while busy.

Source files
------------

// File: rtl/boundary_down_streamer.sv
// Descending counter streamer: latches [min, max] on an accepted start and
// emits max down to min over a valid/ready handshake. Optionally wraps back
// to max, and supports a graceful stop that finishes after the next beat.
module boundary_down_streamer #(
    parameter int unsigned  MAX_COUNT = 10,
    parameter bit           WRAP      = 1'b1,
    localparam int unsigned W         = $clog2(MAX_COUNT)
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         start_in,
    input  logic [W-1:0] max_in,
    input  logic [W-1:0] min_in,
    input  logic         stop_in,
    output logic         count_valid_out,
    input  logic         count_ready_in,
    output logic [W-1:0] count_out,
    output logic         last_out,
    output logic         busy_out,
    output logic         err_out
);

    typedef enum logic [0:0] {StIdle, StRun} state_t;

    state_t       state;
    logic [W-1:0] lat_min;
    logic [W-1:0] lat_max;
    logic         stop_pend;

    logic         at_min;
    logic         finish;
    logic [W-1:0] next_count;

    // Decide what a completed beat does: leave RUN, or move to the next value.
    always_comb begin
        at_min     = (count_out == lat_min);
        // Stop raised in the same cycle as the beat still counts.
        finish     = stop_pend || stop_in || (at_min && !WRAP);
        // Never decrement past min, so no underflow can occur.
        next_count = at_min ? lat_max : count_out - W'(1);
    end

    // Two-state FSM with all outputs registered.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state           <= StIdle;
            lat_min         <= '0;
            lat_max         <= '0;
            stop_pend       <= 1'b0;
            count_out       <= '0;
            count_valid_out <= 1'b0;
            last_out        <= 1'b0;
            busy_out        <= 1'b0;
            err_out         <= 1'b0;
        end else begin
            err_out <= 1'b0;
            case (state)
                StIdle: begin
                    if (start_in) begin
                        if (min_in > max_in) begin
                            err_out <= 1'b1;
                        end else begin
                            state           <= StRun;
                            lat_min         <= min_in;
                            lat_max         <= max_in;
                            stop_pend       <= 1'b0;
                            count_out       <= max_in;
                            count_valid_out <= 1'b1;
                            busy_out        <= 1'b1;
                            last_out        <= (max_in == min_in);
                        end
                    end
                end
                StRun: begin
                    if (count_ready_in) begin
                        if (finish) begin
                            // count_out keeps the final value while idle.
                            state           <= StIdle;
                            stop_pend       <= 1'b0;
                            count_valid_out <= 1'b0;
                            busy_out        <= 1'b0;
                            last_out        <= 1'b0;
                        end else begin
                            count_out <= next_count;
                            last_out  <= (next_count == lat_min);
                        end
                    end else if (stop_in) begin
                        stop_pend <= 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
